// File: rtl/cache_pkg.sv
// Shared cache geometry defaults, entry field layout and way index type.
// Entry layout MSB->LSB: valid, lru, dirty, tag, data.
package cache_pkg;
  localparam int DEF_WAYS            = 4;
  localparam int DEF_LINE_SIZE_BYTES = 4;
  localparam int DEF_LRU_BITS        = 1;
  localparam int DEF_VALID_BITS      = 1;
  localparam int DEF_DIRTY_BITS      = 1;
  localparam int DEF_TAG_BITS        = 18;
  localparam int DEF_DATA_W          = DEF_LINE_SIZE_BYTES * 8;

  localparam int DATA_LSB  = 0;
  localparam int TAG_LSB   = DATA_LSB + DEF_DATA_W;
  localparam int DIRTY_LSB = TAG_LSB + DEF_TAG_BITS;
  localparam int LRU_LSB   = DIRTY_LSB + DEF_DIRTY_BITS;
  localparam int VALID_LSB = LRU_LSB + DEF_LRU_BITS;

  typedef logic [$clog2(DEF_WAYS)-1:0] way_idx_t;
endpackage

// File: rtl/cache_way_sel_prio_enc_lsb.sv
// Lowest-index-first encoder: binary index of the lowest set bit plus a found flag.
module prio_enc_lsb #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);
  always_comb begin
    o_idx   = '0;
    o_found = |i_vec;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/cache_way_sel.sv
// Two-stage way-select / hit-resolution stage: tag compare, hit-way and victim
// selection in S1, word select and output registers in S2, valid/ready on both sides.
module cache_way_sel
  import cache_pkg::*;
#(
  parameter int WAYS            = DEF_WAYS,
  parameter int LINE_SIZE_BYTES = DEF_LINE_SIZE_BYTES,
  parameter int LRU_BITS        = DEF_LRU_BITS,
  parameter int VALID_BITS      = DEF_VALID_BITS,
  parameter int DIRTY_BITS      = DEF_DIRTY_BITS,
  parameter int TAG_BITS        = DEF_TAG_BITS,
  localparam int DATA_W  = LINE_SIZE_BYTES * 8,
  localparam int ENTRY_W = VALID_BITS + LRU_BITS + DIRTY_BITS + TAG_BITS + DATA_W,
  localparam int WORDS   = DATA_W / 32,
  localparam int OFF_W   = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int WAY_W   = $clog2(WAYS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [TAG_BITS-1:0]     i_tag,
  input  logic [OFF_W-1:0]        i_offset,
  input  logic [WAYS*ENTRY_W-1:0] i_entries,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_hit,
  output logic                    o_multi_hit,
  output logic [WAY_W-1:0]        o_way,
  output logic [DATA_W-1:0]       o_line,
  output logic [31:0]             o_word,
  output logic [WAY_W-1:0]        o_victim,
  output logic                    o_victim_dirty
);
  localparam int L_TAG_LSB   = DATA_W;
  localparam int L_DIRTY_LSB = L_TAG_LSB + TAG_BITS;
  localparam int L_LRU_LSB   = L_DIRTY_LSB + DIRTY_BITS;
  localparam int L_VALID_LSB = L_LRU_LSB + LRU_BITS;

  logic [WAYS-1:0]   w_valid, w_dirty, w_lru0, w_match;
  logic [DATA_W-1:0] w_data [WAYS];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_valid[w] = i_entries[w*ENTRY_W + L_VALID_LSB];
      w_dirty[w] = i_entries[w*ENTRY_W + L_DIRTY_LSB];
      w_lru0[w]  = (i_entries[w*ENTRY_W + L_LRU_LSB +: LRU_BITS] == '0);
      w_match[w] = w_valid[w] && (i_entries[w*ENTRY_W + L_TAG_LSB +: TAG_BITS] == i_tag);
      w_data[w]  = i_entries[w*ENTRY_W +: DATA_W];
    end
  end

  logic             w_hit, w_inv_found, w_lru_found;
  logic [WAY_W-1:0] w_hit_way, w_inv_way, w_lru_way;

  prio_enc_lsb #(.N(WAYS), .IDX_W(WAY_W)) u_hit_enc (
    .i_vec(w_match), .o_idx(w_hit_way), .o_found(w_hit));
  prio_enc_lsb #(.N(WAYS), .IDX_W(WAY_W)) u_inv_enc (
    .i_vec(~w_valid), .o_idx(w_inv_way), .o_found(w_inv_found));
  prio_enc_lsb #(.N(WAYS), .IDX_W(WAY_W)) u_lru_enc (
    .i_vec(w_lru0), .o_idx(w_lru_way), .o_found(w_lru_found));

  // Clearing the lowest set bit leaves something only if two or more matched.
  logic w_multi;
  assign w_multi = |(w_match & (w_match - WAYS'(1)));

  logic [DATA_W-1:0] w_line;
  logic [WAY_W-1:0]  w_victim;
  logic              w_victim_dirty;

  always_comb begin
    w_line         = '0;
    w_victim_dirty = 1'b0;
    w_victim       = w_inv_found ? w_inv_way : (w_lru_found ? w_lru_way : '0);
    for (int w = 0; w < WAYS; w++) begin
      if (w_hit && (w_hit_way == WAY_W'(w))) w_line = w_data[w];
      if (w_victim == WAY_W'(w)) w_victim_dirty = w_valid[w] & w_dirty[w];
    end
  end

  logic w_s1_ld, w_s2_ld;
  logic r_s1_v, r_s2_v;
  assign w_s2_ld = !r_s2_v || i_ready;
  assign w_s1_ld = !r_s1_v || w_s2_ld;
  assign o_ready = w_s1_ld;

  logic              r_s1_hit, r_s1_multi, r_s1_vdirty;
  logic [WAY_W-1:0]  r_s1_way, r_s1_victim;
  logic [DATA_W-1:0] r_s1_line;
  logic [OFF_W-1:0]  r_s1_off;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_v      <= 1'b0;
      r_s1_hit    <= 1'b0;
      r_s1_multi  <= 1'b0;
      r_s1_way    <= '0;
      r_s1_line   <= '0;
      r_s1_off    <= '0;
      r_s1_victim <= '0;
      r_s1_vdirty <= 1'b0;
    end else if (w_s1_ld) begin
      r_s1_v <= i_valid;
      if (i_valid) begin
        r_s1_hit    <= w_hit;
        r_s1_multi  <= w_multi;
        r_s1_way    <= w_hit ? w_hit_way : '0;
        r_s1_line   <= w_line;
        r_s1_off    <= i_offset;
        r_s1_victim <= w_victim;
        r_s1_vdirty <= w_victim_dirty;
      end
    end
  end

  logic [31:0] w_word;
  always_comb begin
    w_word = '0;
    if (WORDS == 1) w_word = r_s1_line[31:0];
    else begin
      for (int k = 0; k < WORDS; k++) begin
        if (r_s1_off == OFF_W'(k)) w_word = r_s1_line[32*k +: 32];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_v         <= 1'b0;
      o_hit          <= 1'b0;
      o_multi_hit    <= 1'b0;
      o_way          <= '0;
      o_line         <= '0;
      o_word         <= '0;
      o_victim       <= '0;
      o_victim_dirty <= 1'b0;
    end else if (w_s2_ld) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        o_hit          <= r_s1_hit;
        o_multi_hit    <= r_s1_multi;
        o_way          <= r_s1_way;
        o_line         <= r_s1_line;
        o_word         <= w_word;
        o_victim       <= r_s1_victim;
        o_victim_dirty <= r_s1_vdirty;
      end
    end
  end

  assign o_valid = r_s2_v;
endmodule

// File: tb/tb_cache_way_sel.sv
// Directed scoreboard bench for cache_way_sel with a 4-way, 16-byte-line geometry.
module tb_cache_way_sel;
  import cache_pkg::*;

  localparam int WAYS    = 4;
  localparam int LB      = 16;
  localparam int TB_TAG  = 18;
  localparam int DATA_W  = LB * 8;
  localparam int ENTRY_W = 3 + TB_TAG + DATA_W;

  logic                    i_clk = 1'b0;
  logic                    i_rst, i_valid, i_ready;
  logic                    o_ready, o_valid, o_hit, o_multi_hit, o_victim_dirty;
  logic [TB_TAG-1:0]       i_tag;
  logic [1:0]              i_offset;
  logic [WAYS*ENTRY_W-1:0] i_entries;
  way_idx_t                o_way, o_victim;
  logic [DATA_W-1:0]       o_line;
  logic [31:0]             o_word;

  cache_way_sel #(
    .WAYS(WAYS), .LINE_SIZE_BYTES(LB), .LRU_BITS(1), .VALID_BITS(1),
    .DIRTY_BITS(1), .TAG_BITS(TB_TAG)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_tag(i_tag), .i_offset(i_offset), .i_entries(i_entries),
    .o_valid(o_valid), .i_ready(i_ready), .o_hit(o_hit), .o_multi_hit(o_multi_hit),
    .o_way(o_way), .o_line(o_line), .o_word(o_word), .o_victim(o_victim),
    .o_victim_dirty(o_victim_dirty)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic              hit;
    logic              multi;
    logic [1:0]        way;
    logic [DATA_W-1:0] line;
    logic [31:0]       word;
    logic [1:0]        victim;
    logic              vdirty;
  } exp_t;

  exp_t q[$];
  exp_t m_exp;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk(input logic v, input logic l, input logic d,
                                             input logic [TB_TAG-1:0] tag,
                                             input logic [DATA_W-1:0] data);
    return {v, l, d, tag, data};
  endfunction

  function automatic exp_t ex(input logic hit, input logic multi, input logic [1:0] way,
                              input logic [DATA_W-1:0] line, input logic [31:0] word,
                              input logic [1:0] victim, input logic vdirty);
    exp_t e;
    e.hit = hit; e.multi = multi; e.way = way; e.line = line;
    e.word = word; e.victim = victim; e.vdirty = vdirty;
    return e;
  endfunction

  function automatic logic [31:0] dword(input int k, input int j);
    return 32'hA000_0000 + 32'(k * 16 + j);
  endfunction

  function automatic logic [DATA_W-1:0] dset(input int k);
    return {dword(k, 3), dword(k, 2), dword(k, 1), dword(k, 0)};
  endfunction

  // Reference set: every way valid, lru=1, clean, tag 0x100+way, distinct data.
  function automatic logic [WAYS*ENTRY_W-1:0] eset();
    return {mk(1, 1, 0, 18'h103, dset(3)), mk(1, 1, 0, 18'h102, dset(2)),
            mk(1, 1, 0, 18'h101, dset(1)), mk(1, 1, 0, 18'h100, dset(0))};
  endfunction

  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (q.size() == 0) chk("spurious_output", o_valid, 1'b0);
      else begin
        m_exp = q.pop_front();
        chk("hit", o_hit, m_exp.hit);
        chk("multi_hit", o_multi_hit, m_exp.multi);
        chk("way", o_way, m_exp.way);
        chk("line", o_line, m_exp.line);
        chk("word", o_word, m_exp.word);
        chk("victim", o_victim, m_exp.victim);
        chk("victim_dirty", o_victim_dirty, m_exp.vdirty);
      end
    end
  end

  task automatic drive(input logic [WAYS*ENTRY_W-1:0] ents, input logic [TB_TAG-1:0] tag,
                       input logic [1:0] off, input exp_t e);
    i_entries = ents;
    i_tag     = tag;
    i_offset  = off;
    i_valid   = 1'b1;
    q.push_back(e);
  endtask

  // Holds the request until accepted, then scrambles inputs so late sampling shows up.
  task automatic wait_acc(input string tag);
    logic acc = 1'b0;
    int   n   = 0;
    while (!acc && n < 20) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      n++;
    end
    i_valid   = 1'b0;
    i_entries = '1;
    i_tag     = '1;
    i_offset  = '1;
    chk({tag, "_accepted"}, acc, 1'b1);
  endtask

  task automatic send(input string tag, input logic [WAYS*ENTRY_W-1:0] ents,
                      input logic [TB_TAG-1:0] t, input logic [1:0] off, input exp_t e);
    drive(ents, t, off, e);
    wait_acc(tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_o_valid"}, o_valid, 1'b0);
    chk({tag, "_o_ready"}, o_ready, 1'b1);
    chk({tag, "_o_hit"}, o_hit, 1'b0);
    chk({tag, "_o_multi"}, o_multi_hit, 1'b0);
    chk({tag, "_o_way"}, o_way, 2'd0);
    chk({tag, "_o_line"}, o_line, '0);
    chk({tag, "_o_word"}, o_word, 32'd0);
    chk({tag, "_o_victim"}, o_victim, 2'd0);
    chk({tag, "_o_vdirty"}, o_victim_dirty, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [WAYS*ENTRY_W-1:0] e;
  logic [DATA_W-1:0]       d1, l16;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_tag = '0; i_offset = '0; i_entries = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check_zero_outputs("reset");
    @(posedge i_clk); #1;

    // Single hit on way 2, checking the two-cycle latency.
    e = {mk(1, 1, 0, 18'h003, 128'h33), mk(1, 0, 0, 18'h155, 128'hDEADBEEF),
         mk(1, 1, 0, 18'h002, 128'h22), mk(1, 1, 0, 18'h001, 128'h11)};
    send("t1", e, 18'h155, 2'd0, ex(1, 0, 2, 128'hDEADBEEF, 32'hDEADBEEF, 2, 0));
    @(negedge i_clk);
    chk("latency_cycle1_valid", o_valid, 1'b0);
    @(negedge i_clk);
    chk("latency_cycle2_valid", o_valid, 1'b1);
    @(posedge i_clk); #1;

    // Misses: invalid way first (its dirty bit must not count), then lru-zero, then way 0.
    e = {mk(1, 0, 1, 18'h013, dset(3)), mk(1, 1, 0, 18'h012, dset(2)),
         mk(0, 1, 1, 18'h011, dset(1)), mk(1, 1, 0, 18'h010, dset(0))};
    send("t2", e, 18'h3FF, 2'd1, ex(0, 0, 0, '0, 32'd0, 1, 0));
    e = {mk(1, 0, 1, 18'h013, dset(3)), mk(1, 1, 0, 18'h012, dset(2)),
         mk(1, 1, 0, 18'h011, dset(1)), mk(1, 1, 0, 18'h010, dset(0))};
    send("t3", e, 18'h3FF, 2'd0, ex(0, 0, 0, '0, 32'd0, 3, 1));
    e = {mk(1, 1, 0, 18'h013, dset(3)), mk(1, 1, 0, 18'h012, dset(2)),
         mk(1, 1, 0, 18'h011, dset(1)), mk(1, 1, 1, 18'h010, dset(0))};
    send("t3b", e, 18'h3FF, 2'd0, ex(0, 0, 0, '0, 32'd0, 0, 1));

    // Multi-hit on ways 1 and 3; invalid way 2 with the same tag must not match.
    d1 = 128'h11110000_22220001_33330002_44440003;
    e = {mk(1, 1, 1, 18'h003, dset(3)), mk(0, 1, 0, 18'h003, dset(2)),
         mk(1, 1, 0, 18'h003, d1), mk(1, 1, 0, 18'h004, dset(0))};
    send("t4", e, 18'h003, 2'd1, ex(1, 1, 1, d1, 32'h33330002, 2, 0));

    // Word select across offsets of a 4-word line.
    l16 = 128'h44444444_33333333_22222222_11111111;
    e = {mk(1, 1, 0, 18'h023, dset(3)), mk(1, 1, 0, 18'h022, dset(2)),
         mk(1, 1, 0, 18'h021, dset(1)), mk(1, 1, 0, 18'h020, l16)};
    send("t5_off2", e, 18'h020, 2'd2, ex(1, 0, 0, l16, 32'h33333333, 0, 0));
    send("t5_off3", e, 18'h020, 2'd3, ex(1, 0, 0, l16, 32'h44444444, 0, 0));
    send("t5_off0", e, 18'h020, 2'd0, ex(1, 0, 0, l16, 32'h11111111, 0, 0));
    repeat (4) @(posedge i_clk);
    #1;
    chk("drain_after_directed", q.size(), 0);

    // Backpressure: A, B fill the pipe, C waits; A must hold on the outputs.
    i_ready = 1'b0;
    send("bp_a", eset(), 18'h100, 2'd0, ex(1, 0, 0, dset(0), dword(0, 0), 0, 0));
    send("bp_b", eset(), 18'h101, 2'd0, ex(1, 0, 1, dset(1), dword(1, 0), 0, 0));
    drive(eset(), 18'h102, 2'd0, ex(1, 0, 2, dset(2), dword(2, 0), 0, 0));
    repeat (3) begin
      @(negedge i_clk);
      chk("bp_ready_low", o_ready, 1'b0);
      chk("bp_valid_held", o_valid, 1'b1);
      chk("bp_hold_line", o_line, dset(0));
      chk("bp_hold_way", o_way, 2'd0);
      chk("bp_hold_word", o_word, dword(0, 0));
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    wait_acc("bp_c");
    repeat (4) @(posedge i_clk);
    #1;
    chk("bp_none_lost", q.size(), 0);

    // Reset with two requests in flight.
    i_ready = 1'b0;
    send("rst_x", eset(), 18'h102, 2'd0, ex(1, 0, 2, dset(2), dword(2, 0), 0, 0));
    send("rst_y", eset(), 18'h103, 2'd1, ex(1, 0, 3, dset(3), dword(3, 1), 0, 0));
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    q.delete();
    @(negedge i_clk);
    check_zero_outputs("midstall_reset");
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    send("post_rst", eset(), 18'h101, 2'd2, ex(1, 0, 1, dset(1), dword(1, 2), 0, 0));
    @(negedge i_clk);
    chk("post_rst_cycle1_valid", o_valid, 1'b0);
    @(negedge i_clk);
    chk("post_rst_cycle2_valid", o_valid, 1'b1);
    repeat (3) @(posedge i_clk);
    #1;
    chk("final_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
